// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter and phase sequencer for the shared 8-bit multiplexed memory bus.
// Outputs are registers loaded from the next-state decode, so each bus phase lines up with its FSM state.
module mem_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_rw,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic       m0_ack,
    output logic [7:0] m0_rdata,
    input  logic       m1_req,
    input  logic       m1_rw,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic       m1_ack,
    output logic [7:0] m1_rdata,
    output logic       bus_ale,
    output logic       bus_en,
    output logic       bus_rw,
    output logic [7:0] bus_ad_out,
    output logic       bus_ad_oe,
    input  logic [7:0] bus_ad_in,
    output logic       busy,
    output logic       owner
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    state_t     state_r, state_s;
    logic [2:0] cnt_r, cnt_s;
    logic       last_r, last_s;
    logic       owner_r, owner_s;
    logic       grant_s;
    logic       rw_r, rw_s;
    logic [7:0] addr_r, addr_s;
    logic [7:0] wdata_r, wdata_s;
    logic [7:0] rdata0_r, rdata0_s;
    logic [7:0] rdata1_r, rdata1_s;
    logic       ack0_r, ack0_s;
    logic       ack1_r, ack1_s;
    logic       ale_r, ale_s;
    logic       en_r, en_s;
    logic       bus_rw_r, bus_rw_s;
    logic [7:0] ad_out_r, ad_out_s;
    logic       oe_r, oe_s;
    logic       busy_r, busy_s;

    // Next-state, grant selection and next-cycle bus/ack values
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        last_s   = last_r;
        owner_s  = owner_r;
        grant_s  = 1'b0;
        rw_s     = rw_r;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        rdata0_s = rdata0_r;
        rdata1_s = rdata1_r;
        ack0_s   = 1'b0;
        ack1_s   = 1'b0;
        ale_s    = 1'b0;
        en_s     = 1'b0;
        bus_rw_s = 1'b1;
        ad_out_s = 8'h00;
        oe_s     = 1'b0;
        busy_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // last only moves on contention; a lone requester wins outright
                if (m0_req && m1_req) begin
                    grant_s = ~last_r;
                    last_s  = ~last_r;
                end else if (m1_req) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                if (m0_req || m1_req) begin
                    state_s  = ST_ADDR;
                    owner_s  = grant_s;
                    rw_s     = grant_s ? m1_rw    : m0_rw;
                    addr_s   = grant_s ? m1_addr  : m0_addr;
                    wdata_s  = grant_s ? m1_wdata : m0_wdata;
                    ale_s    = 1'b1;
                    bus_rw_s = rw_s;
                    ad_out_s = addr_s;
                    oe_s     = 1'b1;
                    busy_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s  = ST_DATA;
                cnt_s    = 3'd0;
                en_s     = 1'b1;
                bus_rw_s = rw_r;
                oe_s     = ~rw_r;
                ad_out_s = rw_r ? 8'h00 : wdata_r;
                busy_s   = 1'b1;
            end
            ST_DATA: begin
                busy_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_s = ST_DONE;
                    if (rw_r && owner_r) begin
                        rdata1_s = bus_ad_in;
                    end else if (rw_r) begin
                        rdata0_s = bus_ad_in;
                    end else begin
                        rdata0_s = rdata0_r;
                    end
                    ack0_s = ~owner_r;
                    ack1_s = owner_r;
                end else begin
                    cnt_s    = cnt_r + 3'd1;
                    en_s     = 1'b1;
                    bus_rw_s = rw_r;
                    oe_s     = ~rw_r;
                    ad_out_s = rw_r ? 8'h00 : wdata_r;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, latched transaction fields and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 3'd0;
            last_r   <= 1'b1;
            owner_r  <= 1'b0;
            rw_r     <= 1'b1;
            addr_r   <= 8'h00;
            wdata_r  <= 8'h00;
            rdata0_r <= 8'h00;
            rdata1_r <= 8'h00;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            ale_r    <= 1'b0;
            en_r     <= 1'b0;
            bus_rw_r <= 1'b1;
            ad_out_r <= 8'h00;
            oe_r     <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            last_r   <= last_s;
            owner_r  <= owner_s;
            rw_r     <= rw_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            rdata0_r <= rdata0_s;
            rdata1_r <= rdata1_s;
            ack0_r   <= ack0_s;
            ack1_r   <= ack1_s;
            ale_r    <= ale_s;
            en_r     <= en_s;
            bus_rw_r <= bus_rw_s;
            ad_out_r <= ad_out_s;
            oe_r     <= oe_s;
            busy_r   <= busy_s;
        end
    end

    assign m0_ack     = ack0_r;
    assign m1_ack     = ack1_r;
    assign m0_rdata   = rdata0_r;
    assign m1_rdata   = rdata1_r;
    assign bus_ale    = ale_r;
    assign bus_en     = en_r;
    assign bus_rw     = bus_rw_r;
    assign bus_ad_out = ad_out_r;
    assign bus_ad_oe  = oe_r;
    assign busy       = busy_r;
    assign owner      = owner_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a transaction-level model queues expected bus transactions and
// a negedge monitor compares every cycle; a second instance with WAIT_CYCLES=3 gets a directed read.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    localparam int W       = 1;
    localparam int TXN_LEN = 4 + W;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_rw, m1_req, m1_rw;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic       m0_ack, m1_ack;
    logic [7:0] m0_rdata, m1_rdata;
    logic       bus_ale, bus_en, bus_rw, bus_ad_oe, busy, owner;
    logic [7:0] bus_ad_out, bus_ad_in;

    logic       w3_m0_req, w3_m0_rw;
    logic [7:0] w3_m0_addr, w3_bus_ad_in;
    logic       w3_m0_ack, w3_m1_ack, w3_bus_ale, w3_bus_en, w3_bus_rw, w3_bus_ad_oe, w3_busy, w3_owner;
    logic [7:0] w3_m0_rdata, w3_m1_rdata, w3_bus_ad_out;
    logic       zero1 = 1'b0;
    logic [7:0] zero8 = 8'h00;

    mem_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .bus_ale(bus_ale), .bus_en(bus_en), .bus_rw(bus_rw), .bus_ad_out(bus_ad_out),
        .bus_ad_oe(bus_ad_oe), .bus_ad_in(bus_ad_in), .busy(busy), .owner(owner)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(w3_m0_req), .m0_rw(w3_m0_rw), .m0_addr(w3_m0_addr), .m0_wdata(zero8),
        .m0_ack(w3_m0_ack), .m0_rdata(w3_m0_rdata),
        .m1_req(zero1), .m1_rw(zero1), .m1_addr(zero8), .m1_wdata(zero8),
        .m1_ack(w3_m1_ack), .m1_rdata(w3_m1_rdata),
        .bus_ale(w3_bus_ale), .bus_en(w3_bus_en), .bus_rw(w3_bus_rw), .bus_ad_out(w3_bus_ad_out),
        .bus_ad_oe(w3_bus_ad_oe), .bus_ad_in(w3_bus_ad_in), .busy(w3_busy), .owner(w3_owner)
    );

    always #5 clk = ~clk;

    typedef struct { int m; bit rw; logic [7:0] addr; logic [7:0] wdata; int g; } txn_t;
    typedef struct { int m; int c; } ack_t;

    txn_t       sb_q[$];
    ack_t       ack_log[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         next_idle = 0;
    bit         last_win = 1'b1;
    bit         started  = 1'b0;
    logic       exp_owner = 1'b0;
    logic [7:0] exp_rdata [2];
    txn_t       cur;
    bit         cur_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level reference: decides grants when the bus is free and tracks expected owner/rdata.
    task automatic model_step();
        int   samp;
        bit   winner;
        txn_t t;
        samp = cyc;
        cyc  = cyc + 1;
        if (!rst) begin
            started      = 1'b1;
            next_idle    = samp + 1;
            last_win     = 1'b1;
            exp_owner    = 1'b0;
            exp_rdata[0] = 8'h00;
            exp_rdata[1] = 8'h00;
            cur_valid    = 1'b0;
            sb_q.delete();
        end else if (started) begin
            if (cur_valid && cur.rw && samp == cur.g + 2 + W) exp_rdata[cur.m] = bus_ad_in;
            if (cur_valid && samp >= cur.g + 3 + W) cur_valid = 1'b0;
            if (samp == next_idle) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        winner   = ~last_win;
                        last_win = winner;
                    end else begin
                        winner = m1_req;
                    end
                    t.m     = winner ? 1 : 0;
                    t.rw    = winner ? m1_rw : m0_rw;
                    t.addr  = winner ? m1_addr : m0_addr;
                    t.wdata = winner ? m1_wdata : m0_wdata;
                    t.g     = samp;
                    cur       = t;
                    cur_valid = 1'b1;
                    sb_q.push_back(t);
                    exp_owner = winner;
                    next_idle = samp + TXN_LEN;
                end else begin
                    next_idle = samp + 1;
                end
            end
        end
    endtask

    // Monitor: compares the whole bus/ack picture against the queued transaction each cycle.
    task automatic monitor_cycle();
        logic [14:0] exp_v, act_v, mask_v;
        int          ph;
        txn_t        t;
        bit          done_now;
        exp_v    = {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        mask_v   = 15'h7FFF;
        done_now = 1'b0;
        if (sb_q.size() > 0) begin
            t  = sb_q[0];
            ph = cyc - t.g;
            if (ph == 1) begin
                exp_v = {1'b1, 1'b0, t.rw, 1'b1, t.addr, 1'b1, 1'b0, 1'b0};
            end else if (ph >= 2 && ph <= 2 + W) begin
                exp_v = {1'b0, 1'b1, t.rw, ~t.rw, t.wdata, 1'b1, 1'b0, 1'b0};
                if (t.rw) mask_v[10:3] = 8'h00;
            end else if (ph >= 3 + W) begin
                exp_v = {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, (t.m == 0), (t.m == 1)};
                mask_v[10:3] = 8'h00;
                done_now = 1'b1;
            end
        end
        act_v = {bus_ale, bus_en, bus_rw, bus_ad_oe, bus_ad_out, busy, m0_ack, m1_ack};
        check("bus_phase", act_v & mask_v, exp_v & mask_v);
        check("owner", owner, exp_owner);
        check("m0_rdata", m0_rdata, exp_rdata[0]);
        check("m1_rdata", m1_rdata, exp_rdata[1]);
        if (m0_ack) ack_log.push_back('{0, cyc});
        if (m1_ack) ack_log.push_back('{1, cyc});
        if (done_now) void'(sb_q.pop_front());
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (started) monitor_cycle();
    end

    task automatic wait_ack(input int m, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_ack) || (m == 1 && m1_ack)) begin
                at = cyc;
                break;
            end
        end
        check("ack_seen", (at >= 0), 1);
    endtask

    task automatic rand_master(input logic ack, input logic mine, inout logic req, inout logic rw,
                               inout logic [7:0] addr, inout logic [7:0] wdata);
        if (req && ack) begin
            if ($urandom_range(0, 1) == 0) begin
                req = 1'b0;
            end else begin
                rw = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
            end
        end else if (!req) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 1'b1; rw = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
            end
        end else begin
            if ($urandom_range(0, 9) == 0) begin
                rw = 1'($urandom_range(0, 1)); addr = 8'($urandom); wdata = 8'($urandom);
            end
            if (mine && $urandom_range(0, 19) == 0) req = 1'b0;
        end
    endtask

    initial begin
        int n, at, c0, first;
        rst = 1'b0;
        m0_req = 1'b0; m0_rw = 1'b1; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_req = 1'b0; m1_rw = 1'b1; m1_addr = 8'h00; m1_wdata = 8'h00;
        bus_ad_in = 8'h00;
        w3_m0_req = 1'b0; w3_m0_rw = 1'b1; w3_m0_addr = 8'h00; w3_bus_ad_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", {busy, owner, m0_ack, m1_ack, bus_ale, bus_en, bus_rw, bus_ad_oe}, 8'b0000_0010);
        check("w3_reset_state", {w3_busy, w3_m0_ack, w3_bus_ale, w3_bus_en, w3_m0_rdata}, 12'h000);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // single read by master 0
        bus_ad_in = 8'hA5; m0_rw = 1'b1; m0_addr = 8'h3C; m0_req = 1'b1; c0 = cyc;
        wait_ack(0, at);
        m0_req = 1'b0;
        check("read_latency", at - c0, 3 + W);
        check("read_rdata", m0_rdata, 8'hA5);
        repeat (2) @(negedge clk);

        // single write by master 1
        m1_rw = 1'b0; m1_addr = 8'h80; m1_wdata = 8'h5A; m1_req = 1'b1; c0 = cyc;
        @(negedge clk);
        check("write_addr_phase", {bus_ale, bus_en, bus_rw, bus_ad_oe, bus_ad_out}, {4'b1001, 8'h80});
        @(negedge clk);
        check("write_data_phase", {bus_ale, bus_en, bus_rw, bus_ad_oe, bus_ad_out}, {4'b0101, 8'h5A});
        wait_ack(1, at);
        m1_req = 1'b0;
        check("write_latency", at - c0, 3 + W);
        check("write_owner", owner, 1);
        repeat (2) @(negedge clk);

        // continuous contention for four transactions
        ack_log.delete();
        m0_rw = 1'b1; m1_rw = 1'b1; m0_addr = 8'h20; m1_addr = 8'h21; m0_req = 1'b1; m1_req = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            bus_ad_in = 8'($urandom);
            if (m0_ack || m1_ack) n++;
            if (n == 4) begin m0_req = 1'b0; m1_req = 1'b0; end
        end
        @(negedge clk);
        check("contention_acks", ack_log.size(), 4);
        for (int i = 0; i < ack_log.size() && i < 4; i++) begin
            check("contention_order", ack_log[i].m, i % 2);
            if (i > 0) check("contention_spacing", ack_log[i].c - ack_log[i-1].c, TXN_LEN);
        end
        repeat (2) @(negedge clk);

        // back-to-back reads from master 0 with changing address
        ack_log.delete();
        m0_rw = 1'b1; m0_addr = 8'h10; m0_req = 1'b1; c0 = cyc; n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            bus_ad_in = 8'($urandom);
            if (m0_ack) begin
                n++;
                m0_addr = 8'h10 + n[7:0];
                if (n == 3) m0_req = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_acks", ack_log.size(), 3);
        for (int i = 0; i < ack_log.size() && i < 3; i++) begin
            check("b2b_master", ack_log[i].m, 0);
            check("b2b_ack_cycle", ack_log[i].c - c0, 3 + W + TXN_LEN * i);
        end
        repeat (2) @(negedge clk);

        // reset during the data phase of a master-1 write
        ack_log.delete();
        m1_rw = 1'b0; m1_addr = 8'h77; m1_wdata = 8'h99; m1_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_in_data", {bus_en, bus_ad_oe, owner}, 3'b111);
        rst = 1'b0; m0_rw = 1'b1; m0_addr = 8'h44; m0_req = 1'b1;
        @(negedge clk);
        check("rst_mid_outputs", {busy, owner, m0_ack, m1_ack, bus_ale, bus_en, bus_rw, bus_ad_oe}, 8'b0000_0010);
        check("rst_mid_rdata", {m0_rdata, m1_rdata}, 16'h0000);
        rst = 1'b1;
        n = 0; first = -1;
        for (int i = 0; i < 60 && n < 2; i++) begin
            @(negedge clk);
            bus_ad_in = 8'($urandom);
            if (m0_ack) begin n++; if (first < 0) first = 0; m0_req = 1'b0; end
            if (m1_ack) begin n++; if (first < 0) first = 1; m1_req = 1'b0; end
        end
        check("rst_acks_after", n, 2);
        check("rst_first_grant", first, 0);
        repeat (2) @(negedge clk);

        // randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            bus_ad_in = 8'($urandom);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst = 1'b0;
            rand_master(m0_ack, busy && !owner, m0_req, m0_rw, m0_addr, m0_wdata);
            rand_master(m1_ack, busy && owner, m1_req, m1_rw, m1_addr, m1_wdata);
        end
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
        repeat (10) @(negedge clk);

        // WAIT_CYCLES=3 read: data phase cycles 2..5, capture in cycle 5, ack in cycle 6
        w3_m0_rw = 1'b1; w3_m0_addr = 8'h21; w3_m0_req = 1'b1; w3_bus_ad_in = 8'h40;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("w3_ale", w3_bus_ale, (k == 1));
            check("w3_en", w3_bus_en, (k >= 2 && k <= 5));
            check("w3_ack", w3_m0_ack, (k == 6));
            if (k == 6) begin
                check("w3_rdata", w3_m0_rdata, 8'h45);
                w3_m0_req = 1'b0;
            end
            w3_bus_ad_in = 8'h40 + k[7:0];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
